// File: rtl/ex_div_pkg.sv
// Shared widths, encodings and helpers for the execute-stage iterative divider.
package ex_div_pkg;

   localparam int CPU_WIDTH      = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int FLOW_WIDTH     = 2;
   localparam int DIV_OP_WIDTH   = 2;

   typedef enum logic [FLOW_WIDTH-1:0] {
      FLOW_WORK    = 2'd0,
      FLOW_STOP    = 2'd1,
      FLOW_REFRESH = 2'd2
   } flow_e;

   // bit 0 set = unsigned, bit 1 set = remainder
   typedef enum logic [DIV_OP_WIDTH-1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic [CPU_WIDTH-1:0] abs_val(input logic [CPU_WIDTH-1:0] x);
      return x[CPU_WIDTH-1] ? -x : x;
   endfunction

endpackage

// File: rtl/ex_div_if.sv
// EX-stage divider handshake: operands and flow command in, stall/result out.
interface ex_div_if;
   import ex_div_pkg::*;

   flow_e                     flow_ex_i;
   logic                      div_start_i;
   div_op_e                   div_op_i;
   logic [CPU_WIDTH-1:0]      dividend_i;
   logic [CPU_WIDTH-1:0]      divisor_i;
   logic [REG_ADDR_WIDTH-1:0] reg_wr_adder_i;
   logic                      div_busy_o;
   logic                      div_ready_o;
   logic [CPU_WIDTH-1:0]      div_res_o;
   logic [REG_ADDR_WIDTH-1:0] reg_wr_adder_o;

   modport master (
      output flow_ex_i, div_start_i, div_op_i, dividend_i, divisor_i, reg_wr_adder_i,
      input  div_busy_o, div_ready_o, div_res_o, reg_wr_adder_o
   );

   modport slave (
      input  flow_ex_i, div_start_i, div_op_i, dividend_i, divisor_i, reg_wr_adder_i,
      output div_busy_o, div_ready_o, div_res_o, reg_wr_adder_o
   );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
//  state    | meaning
//  DIV_IDLE | waiting for an accepted start
//  DIV_CALC | 32 restoring steps, cnt_q = 0..31
//  DIV_DONE | result valid, held while flow is STOP
module ex_div
   import ex_div_pkg::*;
(
   input logic     clk,
   input logic     rst_n,
   ex_div_if.slave div
);

   div_state_e                state, state_nxt;
   div_op_e                   op_q;
   logic [REG_ADDR_WIDTH-1:0] tag_q;
   logic                      sgn_a_q, sgn_b_q;
   logic [CPU_WIDTH-1:0]      rem_q, acc_q, dvs_q, res_q;
   logic [4:0]                cnt_q;

   logic                 accept, refresh, in_signed, div_zero, ovf, special;
   logic [CPU_WIDTH-1:0] special_res;
   logic [CPU_WIDTH:0]   rem_sh, trial;
   logic                 ge;
   logic [CPU_WIDTH-1:0] rem_step, quo_step, q_fix, r_fix, res_calc;

   assign refresh     = (div.flow_ex_i == FLOW_REFRESH);
   assign accept      = (state == DIV_IDLE) && div.div_start_i && !refresh;
   assign in_signed   = !div.div_op_i[0];
   assign div_zero    = (div.divisor_i == '0);
   assign ovf         = in_signed && (div.dividend_i == 32'h8000_0000) &&
                        (div.divisor_i == 32'hFFFF_FFFF);
   assign special     = div_zero || ovf;
   assign special_res = div.div_op_i[1] ? (div_zero ? div.dividend_i : '0)
                                        : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

   // acc_q starts as the dividend magnitude and fills with quotient bits from the right
   assign rem_sh   = {rem_q, acc_q[CPU_WIDTH-1]};
   assign trial    = rem_sh - {1'b0, dvs_q};
   assign ge       = !trial[CPU_WIDTH];
   assign rem_step = ge ? trial[CPU_WIDTH-1:0] : rem_sh[CPU_WIDTH-1:0];
   assign quo_step = {acc_q[CPU_WIDTH-2:0], ge};
   assign q_fix    = (!op_q[0] && (sgn_a_q ^ sgn_b_q)) ? -quo_step : quo_step;
   assign r_fix    = (!op_q[0] && sgn_a_q) ? -rem_step : rem_step;
   assign res_calc = op_q[1] ? r_fix : q_fix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= DIV_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DIV_IDLE: if (accept) state_nxt = special ? DIV_DONE : DIV_CALC;
         DIV_CALC: begin
            if (refresh)              state_nxt = DIV_IDLE;
            else if (cnt_q == 5'd31)  state_nxt = DIV_DONE;
         end
         DIV_DONE: if (div.flow_ex_i != FLOW_STOP) state_nxt = DIV_IDLE;
         default:  state_nxt = DIV_IDLE;
      endcase
   end

   always_comb begin
      div.div_busy_o  = 1'b0;
      div.div_ready_o = 1'b0;
      case (state)
         DIV_IDLE: div.div_busy_o  = accept;
         DIV_CALC: div.div_busy_o  = !refresh;
         DIV_DONE: div.div_ready_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= DIV_OP_DIV;
         tag_q   <= '0;
         sgn_a_q <= 1'b0;
         sgn_b_q <= 1'b0;
         rem_q   <= '0;
         acc_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else if (accept) begin
         op_q    <= div.div_op_i;
         tag_q   <= div.reg_wr_adder_i;
         sgn_a_q <= in_signed && div.dividend_i[CPU_WIDTH-1];
         sgn_b_q <= in_signed && div.divisor_i[CPU_WIDTH-1];
         acc_q   <= in_signed ? abs_val(div.dividend_i) : div.dividend_i;
         dvs_q   <= in_signed ? abs_val(div.divisor_i) : div.divisor_i;
         rem_q   <= '0;
         cnt_q   <= '0;
         if (special) res_q <= special_res;
      end else if ((state == DIV_CALC) && !refresh) begin
         rem_q <= rem_step;
         acc_q <= quo_step;
         cnt_q <= cnt_q + 5'd1;
         if (cnt_q == 5'd31) res_q <= res_calc;
      end
   end

   assign div.div_res_o      = res_q;
   assign div.reg_wr_adder_o = tag_q;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: expected results queued at start, checked on the ready rising edge.
module tb_ex_div;
   import ex_div_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   ex_div_if dif ();
   ex_div dut (.clk(clk), .rst_n(rst_n), .div(dif));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic is_special(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic [1:0] o;
      o = op;
      return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] model(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic [1:0] o;
      int sa, sd;
      o = op;
      if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      if (!o[0]) begin
         sa = a;
         sd = b;
         return o[1] ? sa % sd : sa / sd;
      end
      return o[1] ? a % b : a / b;
   endfunction

   // monitor: compare on each rising edge of ready
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) prev = 1'b0;
         else begin
            if (dif.div_ready_o && !prev) begin
               if (sb_q.size() == 0) check("spurious_ready", 32'd1, 32'd0);
               else begin
                  e = sb_q.pop_front();
                  check("res", dif.div_res_o, e.res);
                  check("tag", {27'd0, dif.reg_wr_adder_o}, {27'd0, e.tag});
               end
            end
            prev = dif.div_ready_o;
         end
      end
   end

   task automatic do_div(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int hold);
      exp_t        e;
      int          lat_exp, lat, nbusy;
      logic [31:0] r;
      logic [1:0]  ob;
      r       = model(op, a, b);
      lat_exp = is_special(op, a, b) ? 1 : 33;
      @(negedge clk);
      dif.flow_ex_i      = FLOW_WORK;
      dif.div_start_i    = 1'b1;
      dif.div_op_i       = op;
      dif.dividend_i     = a;
      dif.divisor_i      = b;
      dif.reg_wr_adder_i = tag;
      e.res = r;
      e.tag = tag;
      sb_q.push_back(e);
      #1;
      check("busy_start", {31'd0, dif.div_busy_o}, 32'd1);
      check("ready_idle", {31'd0, dif.div_ready_o}, 32'd0);
      nbusy = 1;
      lat   = 0;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(negedge clk);
         // scramble inputs that must be ignored once the operands are latched
         dif.div_start_i    = 1'($urandom_range(0, 1));
         ob                 = 2'($urandom_range(0, 3));
         dif.div_op_i       = div_op_e'(ob);
         dif.dividend_i     = $urandom;
         dif.divisor_i      = $urandom;
         dif.reg_wr_adder_i = 5'($urandom);
         #1;
         if (dif.div_ready_o) begin
            lat = n;
            dif.div_start_i = 1'b0;
         end else if (dif.div_busy_o) nbusy++;
      end
      dif.div_start_i = 1'b0;
      check("latency", lat, lat_exp);
      check("busy_cycles", nbusy, lat_exp);
      check("busy_done", {31'd0, dif.div_busy_o}, 32'd0);
      if (hold > 0) begin
         dif.flow_ex_i = FLOW_STOP;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check("hold_ready", {31'd0, dif.div_ready_o}, 32'd1);
            check("hold_res", dif.div_res_o, r);
            check("hold_busy", {31'd0, dif.div_busy_o}, 32'd0);
         end
         dif.flow_ex_i = FLOW_WORK;
      end
      @(negedge clk);
      #1;
      check("ready_clr", {31'd0, dif.div_ready_o}, 32'd0);
   endtask

   initial begin
      int          nrdy;
      div_op_e     op;
      logic [1:0]  ob;
      logic [31:0] a, b;

      rst_n              = 1'b0;
      dif.flow_ex_i      = FLOW_WORK;
      dif.div_start_i    = 1'b0;
      dif.div_op_i       = DIV_OP_DIV;
      dif.dividend_i     = '0;
      dif.divisor_i      = '0;
      dif.reg_wr_adder_i = '0;
      #22;
      check("rst_ready", {31'd0, dif.div_ready_o}, 32'd0);
      check("rst_res", dif.div_res_o, 32'd0);
      check("rst_tag", {27'd0, dif.reg_wr_adder_o}, 32'd0);
      check("rst_busy", {31'd0, dif.div_busy_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_div(DIV_OP_DIVU, 32'd100, 32'd7, 5'd5, 0);
      do_div(DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd6, 0);
      do_div(DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, 0);
      do_div(DIV_OP_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
      do_div(DIV_OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd9, 0);
      do_div(DIV_OP_DIVU, 32'd5, 32'd0, 5'd10, 0);
      do_div(DIV_OP_REMU, 32'd5, 32'd0, 5'd11, 0);
      do_div(DIV_OP_DIV,  32'hFFFF_FFFF, 32'd0, 5'd12, 0);
      do_div(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
      do_div(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
      do_div(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);

      // abort at CALC counter 10 (cycle T+11)
      @(negedge clk);
      dif.div_start_i = 1'b1;
      dif.div_op_i    = DIV_OP_DIVU;
      dif.dividend_i  = 32'd100;
      dif.divisor_i   = 32'd7;
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         dif.div_start_i = 1'b0;
      end
      dif.flow_ex_i = FLOW_REFRESH;
      #1;
      check("busy_refresh", {31'd0, dif.div_busy_o}, 32'd0);
      @(negedge clk);
      dif.flow_ex_i = FLOW_WORK;
      #1;
      check("abort_idle_busy", {31'd0, dif.div_busy_o}, 32'd0);
      nrdy = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         #1;
         if (dif.div_ready_o) nrdy++;
      end
      check("abort_no_ready", nrdy, 0);

      do_div(DIV_OP_DIVU, 32'd9, 32'd3, 5'd16, 0);
      do_div(DIV_OP_DIVU, 32'd1000, 32'd10, 5'd17, 3);

      for (int k = 0; k < 6; k++) begin
         ob = 2'($urandom_range(0, 3));
         op = div_op_e'(ob);
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         do_div(op, a, b, 5'(k + 20), 0);
      end

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      dif.div_start_i    = 1'b1;
      dif.div_op_i       = DIV_OP_DIVU;
      dif.dividend_i     = 32'd77;
      dif.divisor_i      = 32'd5;
      dif.reg_wr_adder_i = 5'd31;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         dif.div_start_i = 1'b0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, dif.div_busy_o}, 32'd0);
      check("arst_ready", {31'd0, dif.div_ready_o}, 32'd0);
      check("arst_res", dif.div_res_o, 32'd0);
      check("arst_tag", {27'd0, dif.reg_wr_adder_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
